// File: rtl/cc_unit.sv
// Condition-code producer: nzp generation, MEM/WB CC tracking, CC commit and branch forwarding.
// Define CC_FORWARD_EN to forward in-flight nzp; otherwise branches wait for every producer to commit.
module cc_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic        ex_sets_cc,
  input  logic        ex_is_load,
  input  logic [15:0] ex_result,
  input  logic        mem_resp,
  input  logic [15:0] mem_rdata,
  output logic [2:0]  cc,
  output logic [2:0]  mem_nzp,
  output logic [1:0]  mem_res_bits
);

  function automatic logic [2:0] nzp(input logic [15:0] v);
    logic n, z;
    n = v[15];
    z = (v == '0);
    return {n, z, !n && !z};
  endfunction

  logic       m_v, m_known, w_v;
  logic [2:0] m_nzp, w_nzp;
  logic       m_resolve;
  logic [2:0] m_nzp_res;
  logic [2:0] ex_nzp;
  logic [2:0] rdata_nzp;

  assign ex_nzp    = nzp(ex_result);
  assign rdata_nzp = nzp(mem_rdata);
  assign m_resolve = m_v && !m_known && mem_resp;
  // Resolved MEM value, including load data arriving this cycle.
  assign m_nzp_res = m_resolve ? rdata_nzp : m_nzp;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_v     <= 1'b0;
      m_known <= 1'b0;
      m_nzp   <= 3'b010;
      w_v     <= 1'b0;
      w_nzp   <= 3'b010;
      cc      <= 3'b010;
    end else if (!stall) begin
      m_v     <= ex_sets_cc && !flush;
      m_known <= !ex_is_load;
      m_nzp   <= ex_nzp;
      w_v     <= m_v;
      w_nzp   <= m_nzp_res;
      if (w_v)
        cc <= w_nzp;
    end else begin
      if (flush)
        m_v <= 1'b0;
      if (m_resolve) begin
        m_known <= 1'b1;
        m_nzp   <= rdata_nzp;
      end
    end
  end

`ifdef CC_FORWARD_EN
  always_comb begin
    mem_nzp      = cc;
    mem_res_bits = 2'b00;
    if (m_v) begin
      mem_nzp      = m_nzp_res;
      mem_res_bits = (m_known || mem_resp) ? 2'b11 : 2'b01;
    end else if (w_v) begin
      mem_nzp      = w_nzp;
      mem_res_bits = 2'b11;
    end
  end
`else
  always_comb begin
    mem_nzp      = cc;
    mem_res_bits = (m_v || w_v) ? 2'b01 : 2'b00;
  end
`endif

endmodule

// File: tb/tb_cc_unit.sv
// Directed self-checking bench for cc_unit; expectations follow CC_FORWARD_EN when defined.
module tb_cc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall, flush, ex_sets_cc, ex_is_load, mem_resp;
  logic [15:0] ex_result, mem_rdata;
  logic [2:0]  cc, mem_nzp;
  logic [1:0]  mem_res_bits;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  cc_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .ex_sets_cc(ex_sets_cc), .ex_is_load(ex_is_load), .ex_result(ex_result),
    .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .cc(cc), .mem_nzp(mem_nzp), .mem_res_bits(mem_res_bits)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check forwarding outputs: fwd pair when forwarding is built in, otherwise nzp = cc and the stall code.
  task automatic check_fwd(input string tag, input logic [2:0] f_nzp, input logic [1:0] f_bits,
                           input logic [2:0] nf_nzp, input logic [1:0] nf_bits);
`ifdef CC_FORWARD_EN
    check({tag, "_nzp"}, 16'(mem_nzp), 16'(f_nzp));
    check({tag, "_bits"}, 16'(mem_res_bits), 16'(f_bits));
`else
    check({tag, "_nzp"}, 16'(mem_nzp), 16'(nf_nzp));
    check({tag, "_bits"}, 16'(mem_res_bits), 16'(nf_bits));
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; flush = 1'b0; ex_sets_cc = 1'b0; ex_is_load = 1'b0;
    mem_resp = 1'b0; ex_result = '0; mem_rdata = '0;
    tick(); tick();
    check("rst_cc", 16'(cc), 16'h2);
    check_fwd("rst", 3'b010, 2'b00, 3'b010, 2'b00);
    reset = 1'b0;

    // ALU sequence 8000 then 0000
    ex_sets_cc = 1'b1; ex_result = 16'h8000;
    tick();
    ex_result = 16'h0000;
    check_fwd("alu1", 3'b100, 2'b11, 3'b010, 2'b01);
    tick();
    ex_sets_cc = 1'b0;
    check_fwd("alu2", 3'b010, 2'b11, 3'b010, 2'b01);
    check("alu2_cc", 16'(cc), 16'h2);
    tick();
    check("alu3_cc", 16'(cc), 16'h4);
    check_fwd("alu3", 3'b010, 2'b11, 3'b100, 2'b01);
    tick();
    check("alu4_cc", 16'(cc), 16'h2);
    check_fwd("alu4", 3'b010, 2'b00, 3'b010, 2'b00);

    // Load waiting on memory; ex_result must not leak into the CC
    ex_sets_cc = 1'b1; ex_is_load = 1'b1; ex_result = 16'h8000;
    tick();
    ex_sets_cc = 1'b0; ex_is_load = 1'b0; stall = 1'b1;
    check_fwd("ld1", 3'b100, 2'b01, 3'b010, 2'b01);
    tick();
    check_fwd("ld2", 3'b100, 2'b01, 3'b010, 2'b01);
    tick();
    stall = 1'b0; mem_resp = 1'b1; mem_rdata = 16'h0005;
    #1;
    check_fwd("ld3", 3'b001, 2'b11, 3'b010, 2'b01);
    tick();
    mem_resp = 1'b0; mem_rdata = 16'h8000;
    check_fwd("ld4", 3'b001, 2'b11, 3'b010, 2'b01);
    check("ld4_cc", 16'(cc), 16'h2);
    tick();
    check("ld5_cc", 16'(cc), 16'h1);
    check_fwd("ld5", 3'b001, 2'b00, 3'b001, 2'b00);

    // Asynchronous reset mid-cycle with a producer in MEM
    ex_sets_cc = 1'b1; ex_result = 16'h8000;
    tick();
    ex_sets_cc = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("arst_cc", 16'(cc), 16'h2);
    check_fwd("arst", 3'b010, 2'b00, 3'b010, 2'b00);
    tick();
    reset = 1'b0;
    tick();
    check("arst_rel_cc", 16'(cc), 16'h2);
    check_fwd("arst_rel", 3'b010, 2'b00, 3'b010, 2'b00);

    // Flush while stalled kills the MEM producer
    ex_sets_cc = 1'b1; ex_result = 16'hFFFF;
    tick();
    ex_sets_cc = 1'b0; stall = 1'b1; flush = 1'b1;
    check_fwd("fl0", 3'b100, 2'b11, 3'b010, 2'b01);
    tick();
    stall = 1'b0; flush = 1'b0;
    check_fwd("fl1", 3'b010, 2'b00, 3'b010, 2'b00);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl_cc", 16'(cc), 16'h2);
    end

    // Back-to-back producers A=0001, B=0000
    ex_sets_cc = 1'b1; ex_result = 16'h0001;
    tick();
    ex_result = 16'h0000;
    check_fwd("b2b1", 3'b001, 2'b11, 3'b010, 2'b01);
    tick();
    ex_sets_cc = 1'b0;
    check_fwd("b2b2", 3'b010, 2'b11, 3'b010, 2'b01);
    tick();
    check("b2b3_cc", 16'(cc), 16'h1);
    check_fwd("b2b3", 3'b010, 2'b11, 3'b001, 2'b01);
    tick();
    check("b2b4_cc", 16'(cc), 16'h2);
    check_fwd("b2b4", 3'b010, 2'b00, 3'b010, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
